// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback monitor.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h58;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {UNLOCKED, SETTLING, LOCKED} state_t;

    typedef struct packed {
        logic [3:0] digit;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational pattern-to-digit decoder; illegal patterns report digit 0
// with legal deasserted.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output dec_t       dec
);

    always_comb begin
        dec = '{digit: 4'h0, legal: 1'b1};
        case (seg)
            SEG_0:     dec.digit = 4'd0;
            SEG_1:     dec.digit = 4'd1;
            SEG_2:     dec.digit = 4'd2;
            SEG_3:     dec.digit = 4'd3;
            SEG_4:     dec.digit = 4'd4;
            SEG_5:     dec.digit = 4'd5;
            SEG_6:     dec.digit = 4'd6;
            SEG_7:     dec.digit = 4'd7;
            SEG_8:     dec.digit = 4'd8;
            SEG_9:     dec.digit = 4'd9;
            SEG_BLANK: dec.digit = BCD_BLANK;
            default:   dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_monitor.sv
// Readback monitor for both direction digit buses: samples, filters for
// stability, decodes the locked pattern and tracks illegal-pattern events.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_a,
    input  logic [6:0] seg_b,
    input  logic       err_clr,
    output logic [3:0] bcd_a,
    output logic [3:0] bcd_b,
    output logic       valid,
    output logic       upd,
    output logic       err,
    output logic [7:0] err_cnt
);

    localparam logic [7:0] THRESH = 8'(STABLE_CYCLES);

    logic [13:0] samp_q;
    logic [7:0]  stab_cnt;
    logic [7:0]  cnt_nxt;
    state_t      state;
    dec_t        dec_a;
    dec_t        dec_b;
    logic        changed;
    logic        lock_entry;

    seg7_decode u_dec_a (.seg(samp_q[6:0]),  .dec(dec_a));
    seg7_decode u_dec_b (.seg(samp_q[13:7]), .dec(dec_b));

    // The incoming sample is next cycle's samp_q, so comparing it to the
    // current samp_q flags a change on the same edge samp_q takes it.
    assign changed    = (state == UNLOCKED) || ({seg_b, seg_a} != samp_q);
    assign cnt_nxt    = changed ? 8'd0 :
                        (stab_cnt >= THRESH) ? THRESH : stab_cnt + 8'd1;
    assign lock_entry = !changed && (state == SETTLING) && (cnt_nxt == THRESH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_q   <= '0;
            stab_cnt <= '0;
            state    <= UNLOCKED;
            bcd_a    <= '0;
            bcd_b    <= '0;
            valid    <= 1'b0;
            upd      <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            samp_q   <= {seg_b, seg_a};
            stab_cnt <= cnt_nxt;
            upd      <= 1'b0;

            if (err_clr) begin
                err     <= 1'b0;
                err_cnt <= '0;
            end

            if (changed) begin
                state <= SETTLING;
                valid <= 1'b0;
            end else if (lock_entry) begin
                state <= LOCKED;
                if (dec_a.legal && dec_b.legal) begin
                    bcd_a <= dec_a.digit;
                    bcd_b <= dec_b.digit;
                    valid <= 1'b1;
                    upd   <= (dec_a.digit != bcd_a) || (dec_b.digit != bcd_b);
                end else begin
                    // A clear on the same edge still records this event.
                    valid   <= 1'b0;
                    err     <= 1'b1;
                    err_cnt <= err_clr ? 8'd1 :
                               (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_monitor.sv
// Self-checking bench: run-length reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg7_monitor;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_a = 7'h7F;
    logic [6:0] seg_b = 7'h7F;
    logic       err_clr = 1'b0;
    logic [3:0] bcd_a, bcd_b;
    logic       valid, upd, err;
    logic [7:0] err_cnt;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    seg7_monitor #(.STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .seg_a(seg_a), .seg_b(seg_b), .err_clr(err_clr),
        .bcd_a(bcd_a), .bcd_b(bcd_b), .valid(valid), .upd(upd),
        .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h58, 7'h00, 7'h10};

    // -1 marks an illegal pattern
    function automatic int seg2dig(input logic [6:0] s);
        if (s == 7'h7F) return 15;
        for (int i = 0; i < 10; i++)
            if (pats[i] == s) return i;
        return -1;
    endfunction

    // Model: count how many consecutive edges the same input pair was seen.
    int         run = 0;
    logic [13:0] last_in = '0;
    int         m_a = 0, m_b = 0, m_cnt = 0;
    bit         m_valid = 0, m_upd = 0, m_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            run = 0; m_a = 0; m_b = 0; m_cnt = 0;
            m_valid = 0; m_upd = 0; m_err = 0;
        end else begin
            int da, db;
            if (run == 0 || {seg_b, seg_a} != last_in) run = 1;
            else if (run < 100000) run++;
            last_in = {seg_b, seg_a};
            m_upd = 0;
            if (run == 1) m_valid = 0;
            if (err_clr) begin m_err = 0; m_cnt = 0; end
            if (run == STABLE + 1) begin
                da = seg2dig(seg_a);
                db = seg2dig(seg_b);
                if (da >= 0 && db >= 0) begin
                    m_upd = (da != m_a) || (db != m_b);
                    m_a = da; m_b = db; m_valid = 1;
                end else begin
                    m_valid = 0; m_err = 1;
                    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_bcd_a", int'(bcd_a), m_a);
            check("model_bcd_b", int'(bcd_b), m_b);
            check("model_valid", int'(valid), int'(m_valid));
            check("model_upd",   int'(upd),   int'(m_upd));
            check("model_err",   int'(err),   int'(m_err));
            check("model_cnt",   int'(err_cnt), m_cnt);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int ups;
        step(2);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_bcd_a", int'(bcd_a), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_errcnt", int'(err_cnt), 0);

        // first lock: outputs appear on the 5th edge
        seg_a = 7'h30; seg_b = 7'h12;
        step(4);
        check("lock_early_valid", int'(valid), 0);
        step(1);
        check("lock_bcd_a", int'(bcd_a), 3);
        check("lock_bcd_b", int'(bcd_b), 5);
        check("lock_valid", int'(valid), 1);
        check("lock_upd", int'(upd), 1);
        step(1);
        check("lock_upd_once", int'(upd), 0);

        // countdown 9..0
        ups = 0;
        for (int d = 9; d >= 0; d--) begin
            seg_a = pats[d];
            for (int c = 0; c < 10; c++) begin
                step(1);
                if (upd) ups++;
            end
            check("count_bcd_a", int'(bcd_a), d);
        end
        check("count_upd_pulses", ups, 10);
        check("count_err", int'(err), 0);

        // short glitch is never reported
        seg_a = 7'h12; step(10);
        seg_a = 7'h30;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("glitch_valid", int'(valid), 0);
            check("glitch_bcd_a", int'(bcd_a), 5);
        end
        seg_a = 7'h12; step(10);
        check("glitch_after_bcd_a", int'(bcd_a), 5);
        check("glitch_after_valid", int'(valid), 1);

        // illegal hold counts once
        seg_a = 7'h7E; step(20);
        check("illegal_valid", int'(valid), 0);
        check("illegal_err", int'(err), 1);
        check("illegal_cnt", int'(err_cnt), 1);
        check("illegal_bcd_a", int'(bcd_a), 5);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        check("clr_err", int'(err), 0);
        check("clr_cnt", int'(err_cnt), 0);

        // saturation
        for (int i = 0; i < 300; i++) begin
            seg_a = (i % 2 == 0) ? 7'h7E : 7'h7D;
            step(5);
        end
        check("sat_cnt", int'(err_cnt), 255);
        seg_a = 7'h7E; step(4);
        err_clr = 1'b1; step(1); err_clr = 1'b0;
        check("clr_coinc_cnt", int'(err_cnt), 1);
        check("clr_coinc_err", int'(err), 1);

        // reset mid-settle
        seg_a = 7'h30; seg_b = 7'h12; step(3);
        rst = 1'b1; #1;
        check("rst_bcd_a", int'(bcd_a), 0);
        check("rst_err", int'(err), 0);
        check("rst_cnt", int'(err_cnt), 0);
        step(1); rst = 1'b0;
        step(4);
        check("rst_relock_early", int'(valid), 0);
        step(1);
        check("rst_relock_valid", int'(valid), 1);
        check("rst_relock_bcd_a", int'(bcd_a), 3);
        check("rst_relock_upd", int'(upd), 1);

        // randomized traffic against the model
        for (int s = 0; s < 400; s++) begin
            int hold;
            seg_a = ($urandom_range(0, 9) < 7) ? pats[$urandom_range(0, 9)] : 7'($urandom());
            seg_b = ($urandom_range(0, 9) < 7) ? pats[$urandom_range(0, 9)] : 7'($urandom());
            if ($urandom_range(0, 15) == 0) seg_a = 7'h7F;
            hold = $urandom_range(1, 8);
            for (int c = 0; c < hold; c++) begin
                err_clr = ($urandom_range(0, 15) == 0);
                step(1);
            end
            err_clr = 1'b0;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1; step(1); rst = 1'b0;
            end
        end

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
